// File: rtl/lidar_packet_tx.sv
// 8N1 UART packet transmitter for the LIDAR pixel link (A5, h, v/h, pixel/v).
// Define LIDAR_TX_CHECKSUM_EN to append an XOR checksum byte (b1^b2^b3).
module lidar_packet_tx #(
    parameter int          CLKS_PER_BIT = 645,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        valid_in,
    output logic        ready_out,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        pixel_in,
    output logic        tx_out,
    output logic        busy_out,
    output logic [2:0]  state_out
);

`ifdef LIDAR_TX_CHECKSUM_EN
    localparam int NBYTES = 5;
`else
    localparam int NBYTES = 4;
`endif

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BYTE = 3'(NBYTES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t        state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [2:0]    byte_idx;
    logic [7:0]    shreg;
    logic [10:0]   hcount_q;
    logic [9:0]    vcount_q;
    logic          pixel_q;

    logic [7:0] b1, b2, b3, cur_byte;
    logic       bit_end;

    assign b1        = hcount_q[7:0];
    assign b2        = {vcount_q[4:0], hcount_q[10:8]};
    assign b3        = {2'b00, pixel_q, vcount_q[9:5]};
    assign bit_end   = (baud_cnt == BAUD_LAST);
    assign state_out = state;

    always_comb begin
        cur_byte = SYNC_BYTE;
        case (byte_idx)
            3'd1:    cur_byte = b1;
            3'd2:    cur_byte = b2;
            3'd3:    cur_byte = b3;
`ifdef LIDAR_TX_CHECKSUM_EN
            3'd4:    cur_byte = b1 ^ b2 ^ b3;
`endif
            default: cur_byte = SYNC_BYTE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state     <= IDLE;
            tx_out    <= 1'b1;
            ready_out <= 1'b0;
            busy_out  <= 1'b0;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
            shreg     <= '0;
            hcount_q  <= '0;
            vcount_q  <= '0;
            pixel_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tx_out    <= 1'b1;
                    busy_out  <= 1'b0;
                    ready_out <= 1'b1;
                    if (valid_in && ready_out) begin
                        hcount_q  <= hcount_in;
                        vcount_q  <= vcount_in;
                        pixel_q   <= pixel_in;
                        state     <= START;
                        tx_out    <= 1'b0;
                        ready_out <= 1'b0;
                        busy_out  <= 1'b1;
                        baud_cnt  <= '0;
                        byte_idx  <= '0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                        tx_out   <= cur_byte[0];
                        shreg    <= {1'b0, cur_byte[7:1]};
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state  <= STOP;
                            tx_out <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            tx_out  <= shreg[0];
                            shreg   <= {1'b0, shreg[7:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (byte_idx == LAST_BYTE) begin
                            state    <= DONE;
                            busy_out <= 1'b0;
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                            state    <= START;
                            tx_out   <= 1'b0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                // One idle-high cycle so packets never abut on the line.
                DONE: begin
                    state     <= IDLE;
                    tx_out    <= 1'b1;
                    ready_out <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    tx_out    <= 1'b1;
                    ready_out <= 1'b0;
                    busy_out  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lidar_packet_tx.sv
// Directed + randomized bench for lidar_packet_tx with a byte-level UART model.
// Build with LIDAR_TX_CHECKSUM_EN to expect the fifth checksum byte.
module tb_lidar_packet_tx;

    localparam int CPB = 4;
`ifdef LIDAR_TX_CHECKSUM_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        valid_in = 1'b0;
    logic        ready_out;
    logic [10:0] hcount_in = '0;
    logic [9:0]  vcount_in = '0;
    logic        pixel_in = 1'b0;
    logic        tx_out;
    logic        busy_out;
    logic [2:0]  state_out;

    int vectors = 0;
    int miscompares = 0;

    lidar_packet_tx #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .hcount_in (hcount_in),
        .vcount_in (vcount_in),
        .pixel_in  (pixel_in),
        .tx_out    (tx_out),
        .busy_out  (busy_out),
        .state_out (state_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packet contents straight from the byte layout, using plain arithmetic.
    function automatic void model(input int h, input int v, input int p,
                                  output int b[5]);
        b[0] = 165;
        b[1] = h % 256;
        b[2] = (v % 32) * 8 + h / 256;
        b[3] = p * 32 + v / 32;
        b[4] = b[1] ^ b[2] ^ b[3];
    endfunction

    task automatic present(input int h, input int v, input int p);
        hcount_in = 11'(h);
        vcount_in = 10'(v);
        pixel_in  = 1'(p);
        valid_in  = 1'b1;
    endtask

    // Called at a negedge; receives one packet and checks framing and timing.
    task automatic capture(input string tag, input int h, input int v,
                           input int p, input bit keep_valid,
                           input int nh, input int nv, input int np);
        int w = 0;
        int bad_flags = 0;
        int bad_width = 0;
        int bad_frame = 0;
        int bad_state = 0;
        int exp_b[5];
        logic s[$];
        logic [2:0] st_s[$];
        model(h, v, p, exp_b);
        while (tx_out !== 1'b0 && w < 20) begin
            @(negedge clk_in);
            w++;
        end
        chk($sformatf("%s_latency", tag), w, 1);
        valid_in  = keep_valid;
        hcount_in = 11'(nh);
        vcount_in = 10'(nv);
        pixel_in  = 1'(np);
        for (int i = 0; i < NB * 10 * CPB; i++) begin
            s.push_back(tx_out);
            st_s.push_back(state_out);
            if (busy_out !== 1'b1 || ready_out !== 1'b0) bad_flags++;
            @(negedge clk_in);
        end
        for (int b = 0; b < NB; b++) begin
            logic [7:0] got;
            got = '0;
            for (int j = 0; j < 10; j++) begin
                int base;
                int es;
                base = (b * 10 + j) * CPB;
                es = (j == 0) ? 1 : (j == 9) ? 3 : 2;
                for (int c = 1; c < CPB; c++)
                    if (s[base + c] !== s[base]) bad_width++;
                for (int c = 0; c < CPB; c++)
                    if (int'(st_s[base + c]) != es) bad_state++;
                if (j == 0 && s[base] !== 1'b0) bad_frame++;
                if (j == 9 && s[base] !== 1'b1) bad_frame++;
                if (j >= 1 && j <= 8) got[j - 1] = s[base];
            end
            chk($sformatf("%s_byte%0d", tag, b), got, exp_b[b]);
        end
        chk($sformatf("%s_bitwidth", tag), bad_width, 0);
        chk($sformatf("%s_framing", tag), bad_frame, 0);
        chk($sformatf("%s_flags", tag), bad_flags, 0);
        chk($sformatf("%s_states", tag), bad_state, 0);
        chk($sformatf("%s_done", tag), {tx_out, busy_out, ready_out, state_out},
            {1'b1, 1'b0, 1'b0, 3'd4});
        @(negedge clk_in);
        chk($sformatf("%s_idle", tag), {tx_out, busy_out, ready_out, state_out},
            {1'b1, 1'b0, 1'b1, 3'd0});
    endtask

    initial begin
        int hi_cnt;
        int h, v, p;

        // Reset and idle
        repeat (5) @(negedge clk_in);
        chk("rst_outputs", {tx_out, busy_out, ready_out, state_out},
            {1'b1, 1'b0, 1'b0, 3'd0});
        rst_in = 1'b1;
        chk("ready_before_edge", ready_out, 1'b0);
        @(negedge clk_in);
        chk("ready_first_edge", {ready_out, tx_out, busy_out, state_out},
            {1'b1, 1'b1, 1'b0, 3'd0});
        hi_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (tx_out === 1'b1) hi_cnt++;
            @(negedge clk_in);
        end
        chk("idle_tx_high", hi_cnt, 100);

        // Single packet, inputs scrambled right after acceptance
        present(11'h2B5, 10'h17C, 1);
        capture("single", 11'h2B5, 10'h17C, 1, 1'b0, 11'h000, 10'h3FF, 0);

        // Extremes
        present(2047, 1023, 0);
        capture("extreme", 2047, 1023, 0, 1'b0, 0, 0, 1);

        // Back-to-back with valid held: second point changes mid-packet
        present(11'h123, 10'h2AA, 0);
        capture("b2b_first", 11'h123, 10'h2AA, 0, 1'b1, 11'h5E7, 10'h0C3, 1);
        capture("b2b_second", 11'h5E7, 10'h0C3, 1, 1'b0, 0, 0, 0);

        // Mid-packet reset during DATA of byte 2 (all-zero b2 keeps tx low)
        present(11'h012, 10'h040, 1);
        begin
            int w = 0;
            while (tx_out !== 1'b0 && w < 20) begin
                @(negedge clk_in);
                w++;
            end
        end
        valid_in = 1'b0;
        repeat (20 * CPB + 2 * CPB) @(negedge clk_in);
        chk("midrst_pre", {state_out, tx_out}, {3'd2, 1'b0});
        #1 rst_in = 1'b0;
        #1;
        chk("midrst_async", {tx_out, busy_out, ready_out, state_out},
            {1'b1, 1'b0, 1'b0, 3'd0});
        repeat (3) @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        chk("midrst_ready", ready_out, 1'b1);
        h = int'($urandom_range(2047));
        v = int'($urandom_range(1023));
        p = int'($urandom_range(1));
        present(h, v, p);
        capture("after_rst", h, v, p, 1'b0, 0, 0, 0);

        // Randomized points
        for (int n = 0; n < 6; n++) begin
            h = int'($urandom_range(2047));
            v = int'($urandom_range(1023));
            p = int'($urandom_range(1));
            present(h, v, p);
            capture($sformatf("rand%0d", n), h, v, p, 1'b0,
                    int'($urandom_range(2047)), int'($urandom_range(1023)), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
